// File: rtl/sha256_sigma_cfu.sv
// -----------------------------------------------------------------------------
// sha256_sigma_cfu
//
// Custom function unit that computes the four SHA-256 sigma functions on a
// 32-bit operand. Results pass through PIPE_STAGES elastic pipeline stages.
// Each stage has its own valid bit and can stall on its own, so the unit keeps
// one result per cycle when unstalled. It holds up to PIPE_STAGES requests
// while the consumer applies backpressure.
//
// Parameters
//   PIPE_STAGES : register stages from request to response (legal 1..4)
//   ID_W        : width of the caller tag carried alongside each request
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : asynchronous active-high reset
//   req_valid       : request present
//   req_ready       : request accepted this cycle (combinational from
//                     resp_ready and stage occupancy, never from req_valid)
//   req_function_id : 0 Sum0, 1 Sum1, 2 sigma0, 3 sigma1, 4..7 unsupported
//   req_id          : caller tag, returned on resp_id
//   req_data0       : operand x
//   resp_valid      : response present (registered)
//   resp_ready      : consumer takes the response this cycle
//   resp_data       : result, 0 for unsupported function ids (registered)
//   resp_id         : tag of the request that produced resp_data (registered)
//   resp_error      : request used an unsupported function id (registered)
// -----------------------------------------------------------------------------
module sha256_sigma_cfu #(
   parameter int PIPE_STAGES = 2,
   parameter int ID_W        = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_function_id,
   input  logic [ID_W-1:0] req_id,
   input  logic [31:0]     req_data0,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data,
   output logic [ID_W-1:0] resp_id,
   output logic            resp_error
);

   localparam int LAST = PIPE_STAGES - 1;

   // ------------------------------------------------------------------
   // SHA-256 bit-mixing helpers
   // ------------------------------------------------------------------

   // 32-bit rotate right. The shift count is never 0, so (0 - n) taken
   // modulo 32 is the matching left shift.
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      return (x >> n) | (x << (5'd0 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return ror32(x, 5'd2) ^ ror32(x, 5'd13) ^ ror32(x, 5'd22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return ror32(x, 5'd6) ^ ror32(x, 5'd11) ^ ror32(x, 5'd25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return ror32(x, 5'd7) ^ ror32(x, 5'd18) ^ (x >> 5'd3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return ror32(x, 5'd17) ^ ror32(x, 5'd19) ^ (x >> 5'd10);
   endfunction

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [31:0]           result_data_s;
   logic                  result_err_s;
   logic [PIPE_STAGES-1:0] advance_s;

   logic [PIPE_STAGES-1:0] valid_q;
   logic [PIPE_STAGES-1:0] valid_d;
   logic [31:0]            data_q [PIPE_STAGES];
   logic [31:0]            data_d [PIPE_STAGES];
   logic [ID_W-1:0]        id_q   [PIPE_STAGES];
   logic [ID_W-1:0]        id_d   [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] err_q;
   logic [PIPE_STAGES-1:0] err_d;

   // Operation decode: the result is ready before stage 0 captures it
   always_comb begin
      result_data_s = 32'h0000_0000;
      result_err_s  = 1'b0;
      case (req_function_id)
         3'd0:    result_data_s = big_sigma0(req_data0);
         3'd1:    result_data_s = big_sigma1(req_data0);
         3'd2:    result_data_s = small_sigma0(req_data0);
         3'd3:    result_data_s = small_sigma1(req_data0);
         default: begin
            result_data_s = 32'h0000_0000;
            result_err_s  = 1'b1;
         end
      endcase
   end

   // Stage advance chain: a stage may load when it is empty or when every
   // stage downstream of it can move. A hole anywhere at or after stage k
   // lets k advance, and so does a consumer that is taking the output.
   always_comb begin
      logic chain_open_s;
      chain_open_s = resp_ready;
      advance_s    = '0;
      for (int k = LAST; k >= 0; k--) begin
         chain_open_s = chain_open_s | ~valid_q[k];
         advance_s[k] = chain_open_s;
      end
   end

   // Stage 0 can load exactly when it advances. This path never depends on req_valid.
   assign req_ready = advance_s[0];

   // Next-state for every stage: advancing stages load from upstream
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      err_d   = err_q;

      if (advance_s[0]) begin
         valid_d[0] = req_valid;
         data_d[0]  = result_data_s;
         id_d[0]    = req_id;
         err_d[0]   = result_err_s;
      end else begin
         valid_d[0] = valid_q[0];
      end

      // A stage that advances while its upstream is empty becomes a bubble
      for (int k = 1; k < PIPE_STAGES; k++) begin
         if (advance_s[k]) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
            id_d[k]    = id_q[k-1];
            err_d[k]   = err_q[k-1];
         end else begin
            valid_d[k] = valid_q[k];
         end
      end
   end

   // Pipeline registers: reset clears every stage, so in-flight work is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_q[k] <= 32'h0000_0000;
            id_q[k]   <= '0;
         end
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   // The last stage drives the response directly, so the outputs are registered
   assign resp_valid = valid_q[LAST];
   assign resp_data  = data_q[LAST];
   assign resp_id    = id_q[LAST];
   assign resp_error = err_q[LAST];

endmodule

// File: tb/tb_sha256_sigma_cfu.sv
// -----------------------------------------------------------------------------
// tb_sha256_sigma_cfu
//
// Self-checking bench for sha256_sigma_cfu. It builds three instances, with
// PIPE_STAGES of 2, 1 and 4. One driver and one scoreboard are switched
// between them with 'sel'. The directed vector table, the latency checks, the
// backpressure checks and the reset sequences run on the PIPE_STAGES=2
// instance. A random stream with random resp_ready runs on all three.
// -----------------------------------------------------------------------------
module tb_sha256_sigma_cfu;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic        err;
   } exp_t;

   typedef struct {
      logic [2:0]  fid;
      logic [3:0]  id;
      logic [31:0] x;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rq_valid;
   logic [2:0]  rq_fid;
   logic [3:0]  rq_id;
   logic [31:0] rq_x;
   logic        rresp_ready;
   int          sel;
   int          cur_stages;

   logic [2:0]  dv_ready, dv_rvalid, dv_rerr;
   logic [31:0] dv_rdata [3];
   logic [3:0]  dv_rid   [3];

   logic        m_req_ready, m_resp_valid, m_resp_error;
   logic [31:0] m_resp_data;
   logic [3:0]  m_resp_id;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_dlv   = 0;
   int   cyc     = 0;
   logic last_acc, last_dlv;
   logic hold_prev = 1'b0;
   logic [37:0] snap;
   exp_t pend;
   exp_t exp_q[$];
   int   dlv_cyc[$];
   vec_t tbl[12];
   vec_t bp[4];

   always #5 clk = ~clk;

   sha256_sigma_cfu #(.PIPE_STAGES(2), .ID_W(4)) u_p2 (
      .clk(clk), .rst(rst), .req_valid(rq_valid && (sel == 0)), .req_ready(dv_ready[0]),
      .req_function_id(rq_fid), .req_id(rq_id), .req_data0(rq_x),
      .resp_valid(dv_rvalid[0]), .resp_ready(rresp_ready), .resp_data(dv_rdata[0]),
      .resp_id(dv_rid[0]), .resp_error(dv_rerr[0]));

   sha256_sigma_cfu #(.PIPE_STAGES(1), .ID_W(4)) u_p1 (
      .clk(clk), .rst(rst), .req_valid(rq_valid && (sel == 1)), .req_ready(dv_ready[1]),
      .req_function_id(rq_fid), .req_id(rq_id), .req_data0(rq_x),
      .resp_valid(dv_rvalid[1]), .resp_ready(rresp_ready), .resp_data(dv_rdata[1]),
      .resp_id(dv_rid[1]), .resp_error(dv_rerr[1]));

   sha256_sigma_cfu #(.PIPE_STAGES(4), .ID_W(4)) u_p4 (
      .clk(clk), .rst(rst), .req_valid(rq_valid && (sel == 2)), .req_ready(dv_ready[2]),
      .req_function_id(rq_fid), .req_id(rq_id), .req_data0(rq_x),
      .resp_valid(dv_rvalid[2]), .resp_ready(rresp_ready), .resp_data(dv_rdata[2]),
      .resp_id(dv_rid[2]), .resp_error(dv_rerr[2]));

   // View of the instance currently under test
   always_comb begin
      m_req_ready  = dv_ready[sel];
      m_resp_valid = dv_rvalid[sel];
      m_resp_data  = dv_rdata[sel];
      m_resp_id    = dv_rid[sel];
      m_resp_error = dv_rerr[sel];
   end

   // Reference model: rotate by shifting a doubled word
   function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
      logic [63:0] w;
      w = {v, v} >> n;
      return w[31:0];
   endfunction

   function automatic exp_t model(input logic [2:0] f, input logic [3:0] i, input logic [31:0] x);
      exp_t e;
      e.id  = i;
      e.err = 1'b0;
      case (f)
         3'd0:    e.data = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
         3'd1:    e.data = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
         3'd2:    e.data = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
         3'd3:    e.data = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
         default: begin e.data = 32'h0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   function automatic int stages_of(input int s);
      case (s)
         0:       return 2;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired, got nothing expected completion (t=%0t)", name, $time);
   endtask

   // One clock cycle: sample at the falling edge, update the scoreboard, then return 1 after the rising edge.
   task automatic tick();
      exp_t e;
      logic [37:0] cur;
      @(negedge clk);
      cur      = {m_resp_valid, m_resp_data, m_resp_id, m_resp_error};
      last_acc = rq_valid && m_req_ready && !rst;
      last_dlv = m_resp_valid && rresp_ready && !rst;
      if (hold_prev) chk("stall_stable", cur, snap);
      if (last_dlv) begin
         n_dlv++;
         dlv_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {m_resp_data, m_resp_id, m_resp_error}, 37'h0);
         end else begin
            e = exp_q.pop_front();
            chk("resp", {m_resp_data, m_resp_id, m_resp_error}, {e.data, e.id, e.err});
         end
      end
      if (last_acc) exp_q.push_back(pend);
      hold_prev = m_resp_valid && !rresp_ready && !rst;
      snap      = cur;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input logic [2:0] f, input logic [3:0] i, input logic [31:0] x, input exp_t e);
      rq_valid = 1'b1;
      rq_fid   = f;
      rq_id    = i;
      rq_x     = x;
      pend     = e;
   endtask

   // Hold a request until it is accepted. rq_valid stays high, so
   // consecutive sends run back to back.
   task automatic send(input logic [2:0] f, input logic [3:0] i, input logic [31:0] x, input exp_t e);
      int n;
      set_req(f, i, x, e);
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 50);
      if (!last_acc) fail("send_timeout");
   endtask

   task automatic drain();
      int n;
      rq_valid    = 1'b0;
      rresp_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) fail("drain_timeout");
   endtask

   task automatic measure_latency(input logic [2:0] f, input logic [3:0] i, input logic [31:0] x, input exp_t e);
      int lat;
      send(f, i, x, e);
      rq_valid = 1'b0;
      lat = 1;
      while (!m_resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", lat, cur_stages);
      drain();
   endtask

   task automatic run_random(input int n);
      int   sent, base, guard;
      sent  = 0;
      base  = n_dlv;
      guard = 0;
      rq_valid = 1'b0;
      while ((sent < n || exp_q.size() > 0) && guard < 20000) begin
         if (!rq_valid && sent < n && $urandom_range(0, 9) < 7) begin
            logic [2:0]  f;
            logic [3:0]  i;
            logic [31:0] x;
            f = 3'($urandom_range(0, 7));
            i = 4'($urandom_range(0, 15));
            x = $urandom;
            set_req(f, i, x, model(f, i, x));
         end
         rresp_ready = ($urandom_range(0, 9) < 6);
         tick();
         guard++;
         if (last_acc) begin
            sent++;
            rq_valid = 1'b0;
         end
      end
      rq_valid = 1'b0;
      if (guard >= 20000) fail("random_timeout");
      chk("random_count", n_dlv - base, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, guard, stale, gaps;
      exp_t e;

      tbl[0]  = '{3'd0, 4'd1,  32'h0000_0001, 32'h4008_0400, 1'b0};
      tbl[1]  = '{3'd2, 4'd2,  32'h0000_0001, 32'h0200_4000, 1'b0};
      tbl[2]  = '{3'd3, 4'd3,  32'h0000_0400, 32'h0280_0001, 1'b0};
      tbl[3]  = '{3'd1, 4'd4,  32'h0000_0001, 32'h0420_0080, 1'b0};
      tbl[4]  = '{3'd5, 4'd5,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tbl[5]  = '{3'd0, 4'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      tbl[6]  = '{3'd2, 4'd7,  32'hFFFF_FFFF, 32'h1FFF_FFFF, 1'b0};
      tbl[7]  = '{3'd3, 4'd8,  32'hFFFF_FFFF, 32'h003F_FFFF, 1'b0};
      tbl[8]  = '{3'd1, 4'd9,  32'h8000_0000, 32'h0210_0040, 1'b0};
      tbl[9]  = '{3'd7, 4'd10, 32'h1234_5678, 32'h0000_0000, 1'b1};
      tbl[10] = '{3'd4, 4'd11, 32'h0000_0001, 32'h0000_0000, 1'b1};
      tbl[11] = '{3'd0, 4'd12, 32'h0000_0000, 32'h0000_0000, 1'b0};

      for (int k = 0; k < 4; k++) begin
         bp[k].fid = 3'(k);
         bp[k].id  = 4'(10 + k);
         bp[k].x   = 32'hA5A5_0000 + 32'(k * 32'h1111);
      end

      // Reset state
      sel = 0; cur_stages = 2;
      rst = 1'b1; rq_valid = 1'b0; rq_fid = 3'd0; rq_id = 4'd0; rq_x = 32'h0;
      rresp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {m_resp_valid, m_resp_data, m_resp_id, m_resp_error, m_req_ready},
          {1'b0, 32'h0, 4'h0, 1'b0, 1'b1});
      rst = 1'b0;
      tick();
      chk("ready_after_reset", m_req_ready, 1'b1);

      // Sum1(1), id 3: visible after exactly two cycles
      e = '{32'h0420_0080, 4'd3, 1'b0};
      measure_latency(3'd1, 4'd3, 32'h0000_0001, e);

      // Vector table back to back: one response per cycle
      dlv_cyc.delete();
      for (int i = 0; i < 12; i++) begin
         e = '{tbl[i].exp_data, tbl[i].id, tbl[i].exp_err};
         send(tbl[i].fid, tbl[i].id, tbl[i].x, e);
      end
      drain();
      chk("table_count", dlv_cyc.size(), 12);
      gaps = 0;
      for (int i = 0; i + 1 < dlv_cyc.size(); i++)
         if (dlv_cyc[i+1] - dlv_cyc[i] != 1) gaps++;
      chk("throughput_gaps", gaps, 0);

      // Backpressure: offer 4 requests while stalled
      rresp_ready = 1'b0;
      idx = 0;
      set_req(bp[0].fid, bp[0].id, bp[0].x, model(bp[0].fid, bp[0].id, bp[0].x));
      for (int c = 0; c < 8; c++) begin
         tick();
         if (last_acc) begin
            idx++;
            if (idx < 4) set_req(bp[idx].fid, bp[idx].id, bp[idx].x, model(bp[idx].fid, bp[idx].id, bp[idx].x));
            else rq_valid = 1'b0;
         end
      end
      chk("bp_accepted", idx, cur_stages);
      chk("bp_req_ready", m_req_ready, 1'b0);
      chk("bp_valid_held", m_resp_valid, 1'b1);
      // Release with a request waiting: accept and response in one cycle
      rresp_ready = 1'b1;
      tick();
      chk("bp_simultaneous", {last_acc, last_dlv}, 2'b11);
      chk("bp_occupancy", exp_q.size(), cur_stages);
      if (last_acc) idx++;
      guard = 0;
      while (idx < 4 && guard < 20) begin
         set_req(bp[idx].fid, bp[idx].id, bp[idx].x, model(bp[idx].fid, bp[idx].id, bp[idx].x));
         tick();
         if (last_acc) idx++;
         guard++;
      end
      if (idx < 4) fail("bp_offer_timeout");
      drain();

      // Reset with two requests in flight
      rresp_ready = 1'b0;
      send(3'd0, 4'd1, 32'h0000_00FF, model(3'd0, 4'd1, 32'h0000_00FF));
      send(3'd3, 4'd2, 32'h0000_FF00, model(3'd3, 4'd2, 32'h0000_FF00));
      rq_valid = 1'b0;
      chk("inflight_before_reset", m_resp_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("reset_async_valid", m_resp_valid, 1'b0);
      chk("reset_async_ready", m_req_ready, 1'b1);
      exp_q.delete();
      hold_prev = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      rresp_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (last_dlv) stale++;
      end
      chk("no_stale_resp", stale, 0);
      measure_latency(3'd2, 4'd9, 32'h0000_0001, '{32'h0200_4000, 4'd9, 1'b0});

      // Random stream on every instance
      for (int s = 0; s < 3; s++) begin
         sel = s;
         cur_stages = stages_of(s);
         hold_prev = 1'b0;
         measure_latency(3'd0, 4'd5, 32'h0000_0001, '{32'h4008_0400, 4'd5, 1'b0});
         run_random(300);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
